// File: rtl/pitch_track_select_pkg.sv
// Shared constants for the pitch tracker: widths, the equal-tempered note
// period table (A3..A5 at fs = 61035.15625 Hz) and the nearest-note search.
package pitch_pkg;

  localparam int W     = 16;
  localparam int NOTES = 25;

  localparam logic [4:0] NOTE_NONE = 5'd31;

  // Periods in samples, strictly decreasing from A3 (index 0) to A5 (index 24).
  localparam logic [W-1:0] NOTE_PER [0:NOTES-1] = '{
    16'd277, 16'd262, 16'd247, 16'd233, 16'd220, 16'd208, 16'd196, 16'd185,
    16'd175, 16'd165, 16'd156, 16'd147, 16'd139, 16'd131, 16'd124, 16'd117,
    16'd110, 16'd104, 16'd98,  16'd93,  16'd87,  16'd82,  16'd78,  16'd73,
    16'd69
  };

  typedef enum logic {
    TRK_WAIT,
    TRK_ARMED
  } track_state_t;

  typedef struct packed {
    logic [4:0]   ind;
    logic [W-1:0] per;
  } note_t;

  function automatic logic [W:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] ea;
    logic [W:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  // Scanning from the largest period and replacing only on a strictly smaller
  // distance makes ties resolve to the lower note.
  function automatic note_t nearest_note(input logic [W-1:0] p);
    note_t      best;
    logic [W:0] best_d;
    logic [W:0] d;
    best.ind = 5'd0;
    best.per = NOTE_PER[0];
    best_d   = abs_diff(p, NOTE_PER[0]);
    for (int k = 1; k < NOTES; k++) begin
      d = abs_diff(p, NOTE_PER[k]);
      if (d < best_d) begin
        best.ind = 5'(k);
        best.per = NOTE_PER[k];
        best_d   = d;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/pitch_track_select_if.sv
// Audio-in / pitch-out bundle of the pitch tracker; the slave modport is the
// tracker itself, the master modport is whoever feeds and consumes it.
interface pitch_track_select_if;
  import pitch_pkg::*;

  logic [W-1:0] in;
  logic         enable;
  logic [11:0]  step;
  logic [7:0]   limit;
  logic [W-1:0] wave;
  logic [W-1:0] period;
  logic         period_valid;
  logic [4:0]   note_ind;
  logic [W-1:0] note_per;

  modport master (
    output in, enable, step, limit,
    input  wave, period, period_valid, note_ind, note_per
  );

  modport slave (
    input  in, enable, step, limit,
    output wave, period, period_valid, note_ind, note_per
  );

endinterface

// File: rtl/pitch_track_select_tone_dds.sv
// Square-wave test tone: 20-bit phase accumulator wrapping at limit<<12,
// output high for the first half of each cycle.
module tone_dds
  import pitch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [11:0]  step,
  input  logic [7:0]   limit,
  output logic [W-1:0] wave
);

  logic [19:0] acc;
  logic [19:0] acc_next;
  logic [19:0] m;
  logic [20:0] s;
  logic [20:0] d;

  assign m = {limit, 12'd0};

  always_comb begin
    s        = {1'b0, acc} + {9'd0, step};
    d        = s - {1'b0, m};
    acc_next = s[19:0];
    if (s >= {1'b0, m}) begin
      acc_next = (d >= {1'b0, m}) ? 20'd0 : d[19:0];
    end
  end

  // A zero modulus keeps the phase at 0, which must read as the high half.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc  <= 20'd0;
      wave <= '0;
    end else if (enable) begin
      acc  <= acc_next;
      wave <= ((limit == 8'd0) || (acc < (m >> 1))) ? 16'h3FFF : 16'hC000;
    end
  end

endmodule

// File: rtl/pitch_track_select.sv
// Zero-crossing period meter with nearest-note snapping for the autotune path.
// Define DDS_TONE_EN to analyse an internal test tone instead of the input.
module pitch_track_select
  import pitch_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  pitch_track_select_if.slave bus
);

  logic [W-1:0] x;
  logic         prev_neg;
  logic         crossing;
  logic         publish;
  logic [W-1:0] cnt;
  logic [W-1:0] period_r;
  logic         period_valid_r;
  logic [4:0]   note_ind_r;
  logic [W-1:0] note_per_r;
  note_t        sel;
  track_state_t state;
  track_state_t state_next;

`ifdef DDS_TONE_EN
  logic [W-1:0] tone;
  logic         unused_in;

  tone_dds u_dds (
    .clock  (clock),
    .reset  (reset),
    .enable (bus.enable),
    .step   (bus.step),
    .limit  (bus.limit),
    .wave   (tone)
  );

  assign x         = tone;
  assign bus.wave  = tone;
  assign unused_in = ^bus.in;
`else
  logic unused_dds_cfg;

  assign x              = bus.in;
  assign bus.wave       = '0;
  assign unused_dds_cfg = ^{bus.enable, bus.step, bus.limit};
`endif

  assign crossing = prev_neg & ~x[W-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= TRK_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // The first crossing only establishes a phase reference.
  always_comb begin
    state_next = state;
    publish    = 1'b0;
    if (crossing) begin
      state_next = TRK_ARMED;
      publish    = (state == TRK_ARMED);
    end
  end

  // cnt restarts at 1 on the crossing sample, so at the next crossing it holds
  // the full period in samples; saturation reports silence as 0xFFFF.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_neg       <= 1'b0;
      cnt            <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
    end else begin
      prev_neg <= x[W-1];
      if (crossing) begin
        cnt <= 16'd1;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
      if (publish) begin
        period_r       <= cnt;
        period_valid_r <= 1'b1;
      end
    end
  end

  always_comb begin
    sel = nearest_note(period_r);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      note_ind_r <= NOTE_NONE;
      note_per_r <= '0;
    end else if (period_r == '0) begin
      note_ind_r <= NOTE_NONE;
      note_per_r <= '0;
    end else begin
      note_ind_r <= sel.ind;
      note_per_r <= sel.per;
    end
  end

  assign bus.period       = period_r;
  assign bus.period_valid = period_valid_r;
  assign bus.note_ind     = note_ind_r;
  assign bus.note_per     = note_per_r;

endmodule

// File: tb/tb_pitch_track_select.sv
// Directed bench for pitch_track_select; the DDS scenarios are built when
// DDS_TONE_EN is defined, the external square-wave scenarios otherwise.
module tb_pitch_track_select;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  pitch_track_select_if bus ();

  pitch_track_select dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    bus.in     = 16'h0000;
    bus.enable = 1'b0;
    bus.step   = 12'h000;
    bus.limit  = 8'h00;
    tick(3);
    total++;
    if (bus.period !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_period got=%0d want=0", bus.period);
    end
    total++;
    if (bus.period_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_valid got=%b want=0", bus.period_valid);
    end
    total++;
    if (bus.note_ind !== 5'd31) begin
      bad++;
      $display("[TB] FAIL reset_note_ind got=%0d want=31", bus.note_ind);
    end
    total++;
    if (bus.note_per !== 16'd0) begin
      bad++;
      $display("[TB] FAIL reset_note_per got=%0d want=0", bus.note_per);
    end
    total++;
    if (bus.wave !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL reset_wave got=%h want=0000", bus.wave);
    end
    reset = 1'b1;
    tick(1);
  endtask

`ifndef DDS_TONE_EN

  task automatic drive_square(input int per, input int periods);
    int lo;
    lo = per / 2;
    for (int c = 0; c < periods; c++) begin
      for (int i = 0; i < per; i++) begin
        bus.in = (i < lo) ? 16'hE0C0 : 16'h1F40;
        tick(1);
      end
    end
  endtask

  task automatic test_note(input int per, input logic [4:0] exp_ind, input logic [15:0] exp_per);
    bus.enable = 1'b1;
    bus.step   = 12'h12C;
    bus.limit  = 8'h0A;
    drive_square(per, 4);
    total++;
    if (bus.period !== 16'(per)) begin
      bad++;
      $display("[TB] FAIL period sq=%0d got=%0d want=%0d", per, bus.period, per);
    end
    total++;
    if (bus.period_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL valid sq=%0d got=%b want=1", per, bus.period_valid);
    end
    total++;
    if (bus.note_ind !== exp_ind) begin
      bad++;
      $display("[TB] FAIL note_ind sq=%0d got=%0d want=%0d", per, bus.note_ind, exp_ind);
    end
    total++;
    if (bus.note_per !== exp_per) begin
      bad++;
      $display("[TB] FAIL note_per sq=%0d got=%0d want=%0d", per, bus.note_per, exp_per);
    end
    total++;
    if (bus.wave !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL wave_off sq=%0d got=%h want=0000", per, bus.wave);
    end
  endtask

  task automatic test_silence(input logic [15:0] exp_period);
    bus.in = 16'hE0C0;
    tick(400);
    total++;
    if (bus.period !== exp_period) begin
      bad++;
      $display("[TB] FAIL silence_period got=%0d want=%0d", bus.period, exp_period);
    end
    total++;
    if (bus.period_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL silence_valid got=%b want=1", bus.period_valid);
    end
  endtask

  task automatic test_saturation();
    bus.in = 16'hE0C0;
    tick(65600);
    bus.in = 16'h1F40;
    tick(5);
    total++;
    if (bus.period !== 16'hFFFF) begin
      bad++;
      $display("[TB] FAIL sat_period got=%h want=ffff", bus.period);
    end
    total++;
    if (bus.note_ind !== 5'd0) begin
      bad++;
      $display("[TB] FAIL sat_note_ind got=%0d want=0", bus.note_ind);
    end
    total++;
    if (bus.note_per !== 16'd277) begin
      bad++;
      $display("[TB] FAIL sat_note_per got=%0d want=277", bus.note_per);
    end
  endtask

  task automatic test_reset_mid();
    drive_square(147, 3);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (bus.period !== 16'd0) begin
      bad++;
      $display("[TB] FAIL midrst_period got=%0d want=0", bus.period);
    end
    total++;
    if (bus.period_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_valid got=%b want=0", bus.period_valid);
    end
    total++;
    if (bus.note_ind !== 5'd31) begin
      bad++;
      $display("[TB] FAIL midrst_note_ind got=%0d want=31", bus.note_ind);
    end
    total++;
    if (bus.note_per !== 16'd0) begin
      bad++;
      $display("[TB] FAIL midrst_note_per got=%0d want=0", bus.note_per);
    end
    tick(2);
    reset = 1'b1;
    drive_square(147, 1);
    total++;
    if (bus.period !== 16'd0) begin
      bad++;
      $display("[TB] FAIL one_cross_period got=%0d want=0", bus.period);
    end
    total++;
    if (bus.period_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL one_cross_valid got=%b want=0", bus.period_valid);
    end
    drive_square(147, 1);
    total++;
    if (bus.period !== 16'd147) begin
      bad++;
      $display("[TB] FAIL two_cross_period got=%0d want=147", bus.period);
    end
    total++;
    if (bus.note_ind !== 5'd11) begin
      bad++;
      $display("[TB] FAIL two_cross_note_ind got=%0d want=11", bus.note_ind);
    end
  endtask

`else

  task automatic test_dds_tone();
    int bad_vals;
    bit seen136;
    bit seen137;
    bad_vals   = 0;
    seen136    = 1'b0;
    seen137    = 1'b0;
    bus.step   = 12'h12C;
    bus.limit  = 8'h0A;
    bus.enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (bus.period_valid === 1'b1) begin
        if (bus.period === 16'd136) seen136 = 1'b1;
        else if (bus.period === 16'd137) seen137 = 1'b1;
        else bad_vals++;
      end
    end
    total++;
    if (bad_vals !== 0) begin
      bad++;
      $display("[TB] FAIL tone_period_range got=%0d off-values want=0", bad_vals);
    end
    total++;
    if (seen136 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL tone_seen136 got=%b want=1", seen136);
    end
    total++;
    if (seen137 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL tone_seen137 got=%b want=1", seen137);
    end
    total++;
    if (bus.period_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL tone_valid got=%b want=1", bus.period_valid);
    end
    total++;
    if (bus.note_ind !== 5'd12) begin
      bad++;
      $display("[TB] FAIL tone_note_ind got=%0d want=12", bus.note_ind);
    end
    total++;
    if (bus.note_per !== 16'd139) begin
      bad++;
      $display("[TB] FAIL tone_note_per got=%0d want=139", bus.note_per);
    end
    total++;
    if (bus.wave !== 16'h3FFF && bus.wave !== 16'hC000) begin
      bad++;
      $display("[TB] FAIL tone_wave_level got=%h want=3fff|c000", bus.wave);
    end
  endtask

  task automatic test_reset_mid();
    tick(50);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (bus.period !== 16'd0) begin
      bad++;
      $display("[TB] FAIL midrst_period got=%0d want=0", bus.period);
    end
    total++;
    if (bus.period_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_valid got=%b want=0", bus.period_valid);
    end
    total++;
    if (bus.note_ind !== 5'd31) begin
      bad++;
      $display("[TB] FAIL midrst_note_ind got=%0d want=31", bus.note_ind);
    end
    total++;
    if (bus.wave !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL midrst_wave got=%h want=0000", bus.wave);
    end
    tick(2);
    reset = 1'b1;
    tick(200);
    total++;
    if (bus.period !== 16'd0 || bus.period_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL one_cross_period got=%0d/%b want=0/0", bus.period, bus.period_valid);
    end
    tick(200);
    total++;
    if (bus.period_valid !== 1'b1 || (bus.period !== 16'd136 && bus.period !== 16'd137)) begin
      bad++;
      $display("[TB] FAIL two_cross_period got=%0d/%b want=136|137/1", bus.period, bus.period_valid);
    end
  endtask

  task automatic test_dds_freeze();
    reset      = 1'b0;
    bus.step   = 12'h12C;
    bus.limit  = 8'h0A;
    bus.enable = 1'b0;
    tick(2);
    reset      = 1'b1;
    bus.enable = 1'b1;
    tick(80);
    bus.enable = 1'b0;
    total++;
    if (bus.wave !== 16'hC000) begin
      bad++;
      $display("[TB] FAIL freeze_start_wave got=%h want=c000", bus.wave);
    end
    tick(100);
    total++;
    if (bus.wave !== 16'hC000) begin
      bad++;
      $display("[TB] FAIL freeze_hold_wave got=%h want=c000", bus.wave);
    end
    bus.enable = 1'b1;
    tick(57);
    total++;
    if (bus.wave !== 16'hC000) begin
      bad++;
      $display("[TB] FAIL resume_before_wrap got=%h want=c000", bus.wave);
    end
    tick(1);
    total++;
    if (bus.wave !== 16'h3FFF) begin
      bad++;
      $display("[TB] FAIL resume_after_wrap got=%h want=3fff", bus.wave);
    end
  endtask

  task automatic test_dds_limit0();
    int off_level;
    off_level  = 0;
    reset      = 1'b0;
    bus.step   = 12'h12C;
    bus.limit  = 8'h00;
    bus.enable = 1'b0;
    tick(2);
    reset      = 1'b1;
    bus.enable = 1'b1;
    tick(1);
    for (int i = 0; i < 300; i++) begin
      if (bus.wave !== 16'h3FFF) off_level++;
      tick(1);
    end
    total++;
    if (off_level !== 0) begin
      bad++;
      $display("[TB] FAIL limit0_wave got=%0d non-3fff samples want=0", off_level);
    end
    total++;
    if (bus.period_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL limit0_valid got=%b want=0", bus.period_valid);
    end
    total++;
    if (bus.period !== 16'd0) begin
      bad++;
      $display("[TB] FAIL limit0_period got=%0d want=0", bus.period);
    end
  endtask

`endif

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    #2;
    test_reset();
`ifndef DDS_TONE_EN
    test_note(147, 5'd11, 16'd147);
    test_note(135, 5'd12, 16'd139);
    test_note(300, 5'd0,  16'd277);
    test_note(60,  5'd24, 16'd69);
    test_note(200, 5'd6,  16'd196);
    test_note(100, 5'd18, 16'd98);
    test_silence(16'd100);
    test_saturation();
    test_reset_mid();
`else
    test_dds_tone();
    test_reset_mid();
    test_dds_freeze();
    test_dds_limit0();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
